// File: rtl/apb_param_top_if.sv
// rtl/apb_param_top_if.sv - request/response bundle between CPU-side logic and the APB bridge
// The master side issues transfers; the slave side is the bridge returning status and read data.
interface apb_param_top_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                      transfer;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [ADDR_WIDTH-1:0]     w_addr;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      ready;
  logic                      slverr;
  logic                      busy;

  modport master (
    output transfer, pwrite, r_addr, w_addr, w_data, w_strb,
    input  prdata, ready, slverr, busy
  );

  modport slave (
    input  transfer, pwrite, r_addr, w_addr, w_data, w_strb,
    output prdata, ready, slverr, busy
  );
endinterface

// File: rtl/apb_param_top.sv
// rtl/apb_param_top.sv - APB bridge FSM driving NUM_SLAVES register-file slaves with wait states
// Unmapped addresses are answered by a default responder with PREADY=1, PSLVERR=1.
module apb_param_top #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SLAVES  = 2,
  parameter int SLAVE_DEPTH = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  apb_param_top_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(SLAVE_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            state;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  ready_q;
  logic                  slverr_q;

  logic                  mapped;
  logic [1:0]            sel_idx;
  logic [OFF_W-1:0]      offset;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  take;

  logic [NUM_SLAVES-1:0]                 pready_s;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] rdata_s;

  assign mapped  = ({1'b0, paddr} < (ADDR_WIDTH+1)'(NUM_SLAVES * SLAVE_DEPTH));
  assign sel_idx = 2'(paddr >> OFF_W);
  assign offset  = paddr[OFF_W-1:0];
  assign penable = (state == ACCESS);

  always_comb begin
    psel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      psel[i] = (state != IDLE) && mapped && (sel_idx == 2'(i));
  end

  // With no slave selected the default responder completes immediately.
  always_comb begin
    pready = 1'b1;
    rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel[i]) begin
        pready = pready_s[i];
        rdata  = rdata_s[i];
      end
    end
  end

  // A new request is accepted when idle or in the completion cycle (back-to-back).
  assign take = bus.transfer && ((state == IDLE) || ((state == ACCESS) && pready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pwrite_q <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      prdata_q <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      if (take) begin
        pwrite_q <= bus.pwrite;
        paddr    <= bus.pwrite ? bus.w_addr : bus.r_addr;
        pwdata   <= bus.w_data;
        pstrb    <= bus.w_strb;
      end
      case (state)
        IDLE:   if (bus.transfer) state <= SETUP;
        SETUP:  state <= ACCESS;
        ACCESS: begin
          if (pready) begin
            ready_q  <= 1'b1;
            slverr_q <= ~mapped;
            if (!pwrite_q) prdata_q <= mapped ? rdata : '0;
            state <= bus.transfer ? SETUP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    logic [DATA_WIDTH-1:0] mem [SLAVE_DEPTH];
    logic [1:0]            wcnt;

    assign pready_s[g] = psel[g] && penable && (wcnt == 2'(WAIT_STATES));
    assign rdata_s[g]  = mem[offset];

    always_ff @(posedge clk) begin
      if (rst) begin
        wcnt <= '0;
        for (int w = 0; w < SLAVE_DEPTH; w++) mem[w] <= '0;
      end else begin
        if (psel[g] && penable && !pready_s[g]) wcnt <= wcnt + 2'd1;
        else wcnt <= '0;
        if (pready_s[g] && pwrite_q) begin
          for (int b = 0; b < STRB_W; b++)
            if (pstrb[b]) mem[offset][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.prdata = prdata_q;
  assign bus.ready  = ready_q;
  assign bus.slverr = slverr_q;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_apb_param_top.sv
// tb/tb_apb_param_top.sv - scoreboard bench for apb_param_top (8-bit/1-wait and 16-bit/3-wait instances)
module tb_apb_param_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_param_top_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8))  b0();
  apb_param_top_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) b1();

  apb_param_top #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(2), .SLAVE_DEPTH(64), .WAIT_STATES(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  apb_param_top #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_SLAVES(2), .SLAVE_DEPTH(64), .WAIT_STATES(3))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    bit          rd;
    bit          err;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gaps0 = 0;
  bit b2b_on = 1'b0;
  int busy1_cnt = 0;
  int pen1_cnt = 0;
  int e0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (b0.ready) begin
      if (q0.size() == 0) chk("u0_pending_on_ready", 32'(q0.size()), 32'd1);
      else begin
        m0 = q0.pop_front();
        chk("u0_ready_cycle", cyc, m0.cyc);
        chk("u0_slverr", 32'(b0.slverr), 32'(m0.err));
        if (m0.rd) chk("u0_prdata", 32'(b0.prdata), 32'(m0.data[7:0]));
      end
    end else chk("u0_slverr_idle", 32'(b0.slverr), 32'd0);
    if (b2b_on && !b0.busy) gaps0++;
  end

  always @(negedge clk) begin
    if (b1.ready) begin
      if (q1.size() == 0) chk("u1_pending_on_ready", 32'(q1.size()), 32'd1);
      else begin
        m1 = q1.pop_front();
        chk("u1_ready_cycle", cyc, m1.cyc);
        chk("u1_slverr", 32'(b1.slverr), 32'(m1.err));
        if (m1.rd) chk("u1_prdata", 32'(b1.prdata), 32'(m1.data));
      end
    end
    busy1_cnt += int'(b1.busy);
    pen1_cnt  += int'(u1.penable);
  end

  task automatic drive0(input bit wr, input logic [7:0] a, input logic [7:0] d, input logic s);
    b0.pwrite = wr;
    b0.w_addr = wr ? a : ~a;
    b0.r_addr = wr ? ~a : a;
    b0.w_data = d;
    b0.w_strb = s;
    b0.transfer = 1'b1;
  endtask

  task automatic push0(input bit wr, input bit err, input logic [7:0] rexp, input int at);
    exp_t e;
    e.rd = !wr; e.err = err; e.data = {8'h00, rexp}; e.cyc = at;
    q0.push_back(e);
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (b0.busy && n < 40) begin @(negedge clk); n++; end
    chk("u0_idle_timeout", 32'(b0.busy), 32'd0);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (b1.busy && n < 40) begin @(negedge clk); n++; end
    chk("u1_idle_timeout", 32'(b1.busy), 32'd0);
  endtask

  task automatic s0(input bit wr, input logic [7:0] a, input logic [7:0] d, input logic s,
                    input bit err, input logic [7:0] rexp, input int lat);
    @(negedge clk);
    drive0(wr, a, d, s);
    @(posedge clk); #1;
    push0(wr, err, rexp, cyc + lat);
    @(negedge clk);
    b0.transfer = 1'b0;
    b0.w_data = 8'hEE;
    b0.w_addr = 8'hEE;
    b0.r_addr = 8'hEE;
    wait_idle0();
  endtask

  task automatic s1(input bit wr, input logic [7:0] a, input logic [15:0] d, input logic [1:0] s,
                    input logic [15:0] rexp);
    exp_t e;
    @(negedge clk);
    b1.pwrite = wr;
    b1.w_addr = wr ? a : ~a;
    b1.r_addr = wr ? ~a : a;
    b1.w_data = d;
    b1.w_strb = s;
    b1.transfer = 1'b1;
    @(posedge clk); #1;
    e.rd = !wr; e.err = 1'b0; e.data = rexp; e.cyc = cyc + 5;
    q1.push_back(e);
    @(negedge clk);
    b1.transfer = 1'b0;
    b1.w_data = 16'hEEEE;
    wait_idle1();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t reached before completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    b0.transfer = 1'b0; b0.pwrite = 1'b0; b0.r_addr = '0; b0.w_addr = '0; b0.w_data = '0; b0.w_strb = '0;
    b1.transfer = 1'b0; b1.pwrite = 1'b0; b1.r_addr = '0; b1.w_addr = '0; b1.w_data = '0; b1.w_strb = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", 32'(b0.prdata), 32'd0);
    chk("rst_ready",  32'(b0.ready),  32'd0);
    chk("rst_slverr", 32'(b0.slverr), 32'd0);
    chk("rst_busy",   32'(b0.busy),   32'd0);
    chk("rst_busy1",  32'(b1.busy),   32'd0);
    rst = 1'b0;

    // wr, addr, data, strb, err, read-expect, latency
    s0(1'b1, 8'h10, 8'hA5, 1'b1, 1'b0, 8'h00, 3);
    s0(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'hA5, 3);
    s0(1'b1, 8'h10, 8'h77, 1'b0, 1'b0, 8'h00, 3);
    s0(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'hA5, 3);
    s0(1'b0, 8'h90, 8'h00, 1'b0, 1'b1, 8'h00, 2);
    s0(1'b1, 8'hFF, 8'h3C, 1'b1, 1'b1, 8'h00, 2);
    s0(1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h00, 3);
    s0(1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, 8'h00, 3);

    // back-to-back: transfer held high across three requests
    @(negedge clk);
    drive0(1'b1, 8'h00, 8'h11, 1'b1);
    @(posedge clk); #1;
    e0 = cyc;
    push0(1'b1, 1'b0, 8'h00, e0 + 3);
    @(negedge clk);
    b2b_on = 1'b1;
    drive0(1'b1, 8'h40, 8'h22, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    push0(1'b1, 1'b0, 8'h00, e0 + 6);
    @(negedge clk);
    drive0(1'b0, 8'h00, 8'h99, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    push0(1'b0, 1'b0, 8'h11, e0 + 9);
    @(negedge clk);
    b0.transfer = 1'b0;
    b2b_on = 1'b0;
    wait_idle0();
    chk("b2b_idle_gaps", gaps0, 0);
    s0(1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h22, 3);

    // reset during ACCESS of a write aborts it
    @(negedge clk);
    drive0(1'b1, 8'h20, 8'h5A, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b0.transfer = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy",   32'(b0.busy),   32'd0);
    chk("abort_ready",  32'(b0.ready),  32'd0);
    chk("abort_prdata", 32'(b0.prdata), 32'd0);
    rst = 1'b0;
    s0(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 3);
    s0(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 3);

    // 16-bit data, three wait states
    busy1_cnt = 0;
    pen1_cnt = 0;
    s1(1'b0, 8'h05, 16'h0000, 2'b00, 16'h0000);
    chk("u1_busy_cycles", busy1_cnt, 5);
    chk("u1_penable_cycles", pen1_cnt, 4);
    s1(1'b1, 8'h41, 16'h1234, 2'b11, 16'h0000);
    s1(1'b1, 8'h41, 16'hABCD, 2'b01, 16'h0000);
    s1(1'b0, 8'h41, 16'h0000, 2'b00, 16'h12CD);
    s1(1'b0, 8'h01, 16'h0000, 2'b11, 16'h0000);

    repeat (3) @(negedge clk);
    chk("u0_queue_left", q0.size(), 0);
    chk("u1_queue_left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_param_top.md
Name: apb_param_top

Overview:
- Parametrised APB subsystem: an APB bridge FSM (IDLE/SETUP/ACCESS) drives NUM_SLAVES on-chip register-file slaves over a shared APB bus.
- Adds over the previous generation:
  - configurable address and data widths;
  - multi-slave address decode;
  - per-slave wait states;
  - byte write strobes;
  - PSLVERR for unmapped addresses;
  - back-to-back transfers.
- Sits between a simple request interface (testbench or CPU-side logic) and the peripheral memories.

Parameters:
- ADDR_WIDTH, 8: word-address width of r_addr/w_addr.
- DATA_WIDTH, 8: data width; multiple of 8, range 8..32.
- NUM_SLAVES, 2: number of memory slaves, range 1..4.
- SLAVE_DEPTH, 64: words per slave; power of 2; NUM_SLAVES*SLAVE_DEPTH <= 2^ADDR_WIDTH.
- WAIT_STATES, 1: PREADY low cycles each slave inserts in ACCESS, range 0..3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- transfer  in  1  transfer request; sampled in IDLE and in completion cycle.
- pwrite  in  1  1 = write, 0 = read; captured with request.
- r_addr  in  ADDR_WIDTH  read word address; used when pwrite=0.
- w_addr  in  ADDR_WIDTH  write word address; used when pwrite=1.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  DATA_WIDTH/8  byte write enables; bit i covers byte i.
- prdata  out  DATA_WIDTH  read data of last completed read; registered.
- ready  out  1  one-cycle completion pulse; registered.
- slverr  out  1  error status of the completing transfer; valid while ready=1, otherwise 0.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst=1 at rising edge):
  - FSM -> IDLE; prdata=0, ready=0, slverr=0, busy=0.
  - Internal PSEL, PENABLE and wait counters cleared; all slave memory words cleared to 0.
  - Reset has priority over every other event.
  - Reset during SETUP/ACCESS aborts the transfer: no memory write commits, ready stays 0.
- Request capture:
  - In IDLE with transfer=1, the edge latches pwrite, address (w_addr if pwrite else r_addr), w_data and w_strb into the bridge, and the FSM moves to SETUP.
  - Input changes after capture are ignored until the next capture.
- Address decode:
  - slave index = addr / SLAVE_DEPTH; offset = addr % SLAVE_DEPTH.
  - addr >= NUM_SLAVES*SLAVE_DEPTH selects no slave (unmapped).
- SETUP:
  - Exactly 1 cycle: PSEL of the decoded slave = 1, PENABLE = 0.
  - Next state is always ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - A mapped slave holds PREADY=0 for WAIT_STATES cycles, then PREADY=1.
  - The unmapped-address default responder gives PREADY=1 and PSLVERR=1 in the first ACCESS cycle.
  - The bus signals stay stable while PREADY=0.
- Completion (ACCESS with PREADY=1):
  - Mapped write: at that edge, each byte i with w_strb[i]=1 is written; other bytes are kept.
  - Mapped read: prdata <= slave word.
  - Unmapped access: no write; read loads prdata <= 0.
  - At the same edge: ready <= 1 and slverr <= PSLVERR, both for exactly one cycle.
- Latency:
  - Request sampled at edge E; ready is high in the cycle after edge E+2+WAIT_STATES.
  - For unmapped addresses, ready is high in the cycle after edge E+2.
- Back-to-back:
  - If transfer=1 in the completion cycle, the new request is captured at the same edge and the FSM goes directly to SETUP.
  - busy stays 1 and there is no IDLE cycle.
  - Otherwise the FSM goes to IDLE.
- Reads ignore w_strb. prdata holds its value until the next read completes or reset.
- Write/read to the same address in consecutive transfers: the read returns the newly written data.

Test Plan:
- Defaults: write 8'hA5 to 8'h10 (strb=1), then read 8'h10 -> ready pulses twice, slverr=0, prdata=8'hA5 after the second pulse.
- WAIT_STATES=3: single read of 8'h05 -> ready high exactly in the cycle after edge E+5; PENABLE high for 4 cycles; busy high for 5 cycles.
- DATA_WIDTH=16: write 16'h1234 strb=2'b11 to 8'h41, then write 16'hABCD strb=2'b01, then read -> prdata=16'h12CD (slave 1, offset 1).
- Unmapped (defaults): read 8'h90 -> ready after E+2, slverr=1, prdata=0. Write 8'hFF -> slverr=1, no slave word modified.
- Back-to-back: transfer held high for writes to 8'h00 and 8'h40, then a read of 8'h00 -> busy continuously 1, three ready pulses, no IDLE between transfers.
- Reset mid-ACCESS of a write of 8'h5A to 8'h20 -> ready never pulses, busy=0 after the reset edge, subsequent read of 8'h20 returns 8'h00.
